// File: rtl/alu_cmd_deserializer.sv
// Serial command receiver: decodes 11-bit frames into {B, A, opcode} and
// validates framing, byte count, CRC4 and opcode before presenting a command or an error.
module alu_cmd_deserializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        cmd_valid,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  opcode,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  localparam int unsigned BIT_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [BIT_W-1:0] TYPE_BIT  = 4'd1;
  localparam logic [BIT_W-1:0] PAY_FIRST = 4'd2;
  localparam logic [BIT_W-1:0] PAY_LAST  = 4'd9;
  localparam logic [BIT_W-1:0] STOP_BIT  = 4'd10;
  localparam logic [CNT_W-1:0] FULL_CNT  = 4'd8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BITS  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [2:0] F_DATA = 3'b100;
  localparam logic [2:0] F_CRC  = 3'b010;
  localparam logic [2:0] F_OP   = 3'b001;

  logic [1:0]       state, state_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic             frame_type;
  logic [6:0]       pay;
  logic [CNT_W-1:0] byte_cnt;
  logic [3:0]       crc_run;
  logic [63:0]      data_sr;

  logic             stop_edge_c;
  logic             in_payload_c;
  logic             start_c;
  logic             ev_cmd_c;
  logic             ev_err_c;
  logic [2:0]       ev_flags_c;
  logic [3:0]       crc_calc_c;

  // One MSB-first step of CRC4 with polynomial x^4+x+1.
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // DONE behaves like IDLE so a start bit right after a stop bit is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = sin ? S_IDLE : S_BITS;
      S_BITS:         if (bit_cnt == STOP_BIT) state_nxt = sin ? S_DONE : S_FLUSH;
      S_FLUSH:        if (sin) state_nxt = S_IDLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Frame evaluation happens on the edge that samples the stop bit.
  always_comb begin
    stop_edge_c  = (state == S_BITS) && (bit_cnt == STOP_BIT);
    in_payload_c = (state == S_BITS) && (bit_cnt >= PAY_FIRST) && (bit_cnt <= PAY_LAST);
    start_c      = ((state == S_IDLE) || (state == S_DONE)) && !sin;
    // Finish the running data CRC with the marker bit and the received opcode.
    crc_calc_c   = crc_step(crc_step(crc_step(crc_step(crc_run, 1'b1), pay[6]), pay[5]), pay[4]);
    ev_cmd_c     = 1'b0;
    ev_err_c     = 1'b0;
    ev_flags_c   = 3'b000;
    if (stop_edge_c) begin
      if (!sin) begin
        ev_err_c   = 1'b1;
        ev_flags_c = F_DATA;
      end else if (!frame_type) begin
        if (byte_cnt == FULL_CNT) begin
          ev_err_c   = 1'b1;
          ev_flags_c = F_DATA;
        end
      end else if (byte_cnt != FULL_CNT) begin
        ev_err_c   = 1'b1;
        ev_flags_c = F_DATA;
      end else if (crc_calc_c != pay[3:0]) begin
        ev_err_c   = 1'b1;
        ev_flags_c = F_CRC;
      end else if (pay[5]) begin
        // Legal opcodes 000/001/100/101 all have bit 1 clear.
        ev_err_c   = 1'b1;
        ev_flags_c = F_OP;
      end else begin
        ev_cmd_c   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      frame_type <= 1'b0;
      pay        <= '0;
      byte_cnt   <= '0;
      crc_run    <= '0;
      data_sr    <= '0;
    end else begin
      if (start_c)                 bit_cnt <= TYPE_BIT;
      else if (state == S_BITS)    bit_cnt <= bit_cnt + BIT_W'(1);
      if ((state == S_BITS) && (bit_cnt == TYPE_BIT)) frame_type <= sin;
      if (in_payload_c) begin
        pay <= {pay[5:0], sin};
        if (!frame_type) begin
          data_sr <= {data_sr[62:0], sin};
          crc_run <= crc_step(crc_run, sin);
        end
      end
      if (stop_edge_c) begin
        if (ev_err_c || frame_type) begin
          byte_cnt <= '0;
          crc_run  <= '0;
        end else begin
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;
      err_flags <= 3'b000;
      A         <= '0;
      B         <= '0;
      opcode    <= 3'b000;
    end else begin
      cmd_valid <= ev_cmd_c;
      err_valid <= ev_err_c;
      if (ev_err_c) err_flags <= ev_flags_c;
      if (ev_cmd_c) begin
        A      <= data_sr[31:0];
        B      <= data_sr[63:32];
        opcode <= pay[6:4];
      end
    end
  end

endmodule

// File: doc/alu_cmd_deserializer.md
# alu_cmd_deserializer

Serial command receiver at the ALU input. It decodes the 11-bit frames arriving on `sin` into one command: operand B, operand A, then a control byte carrying the opcode and CRC. It checks framing, byte count, CRC and opcode, then presents either a decoded command or error flags to the ALU core. Its output pairs with the response serializer on `sout`.

## Interface
- No parameters.
- `clk` in 1: system clock; `sin` sampled on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sin` in 1: serial input, idle high, one bit per `clk`.
- `cmd_valid` out 1: one-cycle pulse, error-free command on `A`/`B`/`opcode`.
- `A` out 32: operand A; holds until next `cmd_valid`.
- `B` out 32: operand B; holds until next `cmd_valid`.
- `opcode` out 3: AND=000, OR=001, ADD=100, SUB=101.
- `err_valid` out 1: one-cycle pulse, command rejected.
- `err_flags` out 3: {err_data, err_crc, err_op}, one-hot; holds until next `err_valid`.

## Operation
- **Frame** (bit 0 first): start=0, type (0=data, 1=ctl), payload[7:0] MSB first, stop=1.
- **Command:** 8 data frames, B[31:24] down to A[7:0], then one ctl frame.
- **Ctl payload:** {1'b0, opcode[2:0], crc[3:0]}.
- **CRC4:** polynomial x^4+x+1, init 0, computed MSB first over the 68 bits {B, A, 1'b1, opcode}.
- **FSM states:**
  - IDLE: a sampled `sin`=0 moves to BITS.
  - BITS: count bits 1..10.
  - DONE: decode the byte and go to IDLE.
  - FLUSH: wait for `sin`=1, then go to IDLE.
- **Byte count:** 0..8. A data frame increments it. A ctl frame triggers evaluation and clears it.
- **Error rules** (only the highest-priority flag is reported):
  - err_data: a ctl frame arrives with count≠8, a data frame arrives with count=8, or a stop bit samples 0. Count clears. A stop error goes to FLUSH; the others go to IDLE.
  - err_crc: count=8 and the received CRC≠computed CRC.
  - err_op: CRC is good and the opcode is not one of the four legal codes.
- **Priority:** err_data > err_crc > err_op.
- **On error:** `A`/`B`/`opcode` are not updated.
- **Staging:** partial bytes are held internally. Outputs change only on evaluation.

## Timing
- **Reset values:**
  - `cmd_valid`=0, `err_valid`=0, `err_flags`=0, `A`=0, `B`=0, `opcode`=000.
  - FSM=IDLE, byte count=0, CRC state=0.
- **Mid-frame reset:** a partial frame or command is discarded. Nothing is emitted on reset release.
- **Latency:** `cmd_valid` or `err_valid` is high for exactly the one cycle after the edge that samples the ctl stop bit. A stop-bit error pulses `err_valid` in the cycle after the bad stop bit is sampled.
- **Back-to-back frames:**
  - A start bit sampled on the edge right after a stop bit is accepted; no idle bits are required.
  - The output pulse and the first bit of the next frame may coincide.
- **Exclusivity:** `cmd_valid` and `err_valid` are never high together.
- **Idle gaps:** any number of idle high bits between frames is allowed. There is no timeout.
- **Throughput:** one command per 99 bit-times minimum. No backpressure; the consumer must accept each pulse.

## Test plan
- **Good AND:** B=0, A=0, ctl payload 0x0B (opcode 000, CRC 4'hB) -> `cmd_valid` pulse, A=0, B=0, opcode=000; `err_valid` stays 0.
- **Good ADD:** B=0x00000002, A=0x00000001, opcode 100, model CRC -> `cmd_valid`, A=1, B=2, opcode=100. Repeat back-to-back with zero idle bits; two pulses 99 cycles apart.
- **Bad CRC:** same as the first case with CRC 4'hC -> `err_valid`, err_flags=3'b010; A/B/opcode keep their previous values.
- **Short command:** 7 data frames then a ctl frame -> `err_valid`, err_flags=3'b100. A following good command decodes normally.
- **Bad opcode:** opcode 111 with correct CRC -> `err_valid`, err_flags=3'b001. Separately, a stop bit forced to 0 on data frame 3 -> err_flags=3'b100 and FSM in FLUSH until `sin`=1.
- **Reset mid-command:** assert `rst` asynchronously during frame 5 -> all outputs 0 at once. A full good command after release decodes correctly.
